// File: rtl/rv32_instr_encoder_pkg.sv
// Purpose : shared constants for the RV32I instruction encoder (op-kind codes,
//           major opcodes, shift funct3 values) and the loader FSM state type.
// Ports   : none (package).
package rv32_instr_encoder_pkg;

    // Descriptor kind codes carried on i_op_kind; 9..15 are illegal.
    localparam logic [3:0] OPKIND_ALU_R  = 4'd0;
    localparam logic [3:0] OPKIND_ALU_I  = 4'd1;
    localparam logic [3:0] OPKIND_LOAD   = 4'd2;
    localparam logic [3:0] OPKIND_STORE  = 4'd3;
    localparam logic [3:0] OPKIND_BRANCH = 4'd4;
    localparam logic [3:0] OPKIND_JAL    = 4'd5;
    localparam logic [3:0] OPKIND_JALR   = 4'd6;
    localparam logic [3:0] OPKIND_LUI    = 4'd7;
    localparam logic [3:0] OPKIND_AUIPC  = 4'd8;

    // RV32I major opcodes.
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    // Immediate-shift funct3 values (SLLI, SRLI/SRAI).
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } enc_state_e;

endpackage

// File: rtl/rv32_imm_packer.sv
// Purpose : combinational RV32I packer: kind + fields + immediate -> 32-bit word,
//           plus illegal-kind and immediate-range violation flags.
// Ports   : kind_i, funct3_i, alt_i, rd_i, rs1_i, rs2_i, imm_i -> word_o, illegal_o, range_err_o.
// Config  : ENCODER_RANGE_CHECK_EN enables immediate range checking; otherwise
//           immediates are truncated to their fields and range_err_o is 0.
module rv32_imm_packer
    import rv32_instr_encoder_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [2:0]  funct3_i,
    input  logic        alt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    logic is_shift;
    assign is_shift = (funct3_i == FUNCT3_SLL) || (funct3_i == FUNCT3_SRL_SRA);

    always_comb begin
        word_o    = 32'h0;
        illegal_o = 1'b0;
        case (kind_i)
            OPKIND_ALU_R:  word_o = {1'b0, alt_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPCODE_OP};
            OPKIND_ALU_I: begin
                // Shifts reuse the top of the I immediate as funct7 (SRAI alt bit).
                if (is_shift)
                    word_o = {1'b0, alt_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OPCODE_OP_IMM};
                else
                    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPCODE_OP_IMM};
            end
            OPKIND_LOAD:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPCODE_LOAD};
            OPKIND_STORE:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPCODE_STORE};
            OPKIND_BRANCH: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                     imm_i[4:1], imm_i[11], OPCODE_BRANCH};
            OPKIND_JAL:    word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPCODE_JAL};
            OPKIND_JALR:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPCODE_JALR};
            OPKIND_LUI:    word_o = {imm_i[19:0], rd_i, OPCODE_LUI};
            OPKIND_AUIPC:  word_o = {imm_i[19:0], rd_i, OPCODE_AUIPC};
            default:       illegal_o = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // A value fits N signed bits when bits [31:N-1] are all copies of the sign.
    logic fit12, fit13, fit21;
    assign fit12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fit13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fit21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        range_err_o = 1'b0;
        case (kind_i)
            OPKIND_ALU_I:  range_err_o = is_shift ? (|imm_i[31:5]) : ~fit12;
            OPKIND_LOAD,
            OPKIND_STORE,
            OPKIND_JALR:   range_err_o = ~fit12;
            OPKIND_BRANCH: range_err_o = ~fit13 | imm_i[0];
            OPKIND_JAL:    range_err_o = ~fit21 | imm_i[0];
            default:       range_err_o = 1'b0;
        endcase
    end
`else
    // Upper immediate bits are simply truncated away in this build.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_i[31:21];
    assign range_err_o   = 1'b0;
`endif

endmodule

// File: rtl/rv32_instr_encoder.sv
// Purpose : streaming RV32I encoder/loader; accepts descriptors over valid/ready
//           and writes packed words to consecutive I_MEM byte addresses.
// Ports   : i_clk/i_rst (sync, active-high), i_start/i_base_addr session control,
//           i_op_* descriptor handshake, o_imem_* write port, o_busy/o_done/o_error/o_count status.
// Config  : ENCODER_RANGE_CHECK_EN (in rv32_imm_packer) turns immediate violations into errors.
module rv32_instr_encoder
    import rv32_instr_encoder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_base_addr,
    input  logic                   i_op_valid,
    output logic                   o_op_ready,
    input  logic [3:0]             i_op_kind,
    input  logic [2:0]             i_funct3,
    input  logic                   i_alt,
    input  logic [4:0]             i_rd,
    input  logic [4:0]             i_rs1,
    input  logic [4:0]             i_rs2,
    input  logic [31:0]            i_imm,
    input  logic                   i_last,
    output logic                   o_imem_we,
    output logic [ADDR_W-1:0]      o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0] word;
    logic        illegal, range_err, xfer, full;

    logic [1:0] unused_base_lo;
    assign unused_base_lo = i_base_addr[1:0];

    rv32_imm_packer u_packer (
        .kind_i      (i_op_kind),
        .funct3_i    (i_funct3),
        .alt_i       (i_alt),
        .rd_i        (i_rd),
        .rs1_i       (i_rs1),
        .rs2_i       (i_rs2),
        .imm_i       (i_imm),
        .word_o      (word),
        .illegal_o   (illegal),
        .range_err_o (range_err)
    );

    assign xfer = i_op_valid && (state_q == ST_RUN);
    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = 1'b0;
        // Done fires the cycle after the write that carried i_last.
        done_d  = we_q && last_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (xfer) begin
                    if (illegal || range_err || full) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word;
                        ptr_d   = ptr_q + ADDR_W'(4);
                        count_d = count_q + CNT_W'(1);
                        last_d  = i_last;
                        if (i_last)
                            state_d = ST_DONE;
                    end
                end
            end
            default: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                    count_d = '0;
                    ptr_d   = {i_base_addr[ADDR_W-1:2], 2'b00};
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_op_ready   = (state_q == ST_RUN);
    assign o_busy       = (state_q == ST_RUN);
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_done       = done_q;
    assign o_error      = err_q;
    assign o_count      = count_q;

endmodule
